// File: rtl/store_monitor_if.sv
// Bundles the processor data-memory write port observed by the store monitor
// together with the monitor's verdict outputs.
interface store_monitor_if;
    logic        memwrite;
    logic [31:0] pc;
    logic [31:0] aluout;
    logic [31:0] writedata;
    logic        done;
    logic        pass;
    logic        fail;
    logic [1:0]  fail_code;
    logic [15:0] store_count;
    logic [31:0] bad_data;
    logic [31:0] last_pc;
    logic [1:0]  dbg_state;

    // No handshake: memwrite is a one-cycle strobe that qualifies aluout/writedata
    // on every rising edge; the monitor never back-pressures the processor.
    modport master (
        output memwrite, pc, aluout, writedata,
        input  done, pass, fail, fail_code, store_count, bad_data, last_pc, dbg_state
    );

    modport slave (
        input  memwrite, pc, aluout, writedata,
        output done, pass, fail, fail_code, store_count, bad_data, last_pc, dbg_state
    );
endinterface

// File: rtl/store_monitor.sv
// Watches processor stores for the final result write and latches a sticky
// pass/fail verdict, with a cycle-count timeout as the fallback verdict.
module store_monitor #(
    parameter logic [31:0] EXP_ADDR = 32'h00000054,
    parameter logic [31:0] EXP_DATA = 32'h00000007,
    parameter logic [15:0] TIMEOUT  = 16'd1000
) (
    input logic           clk,
    input logic           reset,
    store_monitor_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } state_t;

    localparam logic [15:0] LP_LAST_CYCLE = TIMEOUT - 16'd1;

    state_t      r_state, w_next_state;
    logic [15:0] r_cycles, w_next_cycles;
    logic [15:0] r_store_count, w_next_store_count;
    logic [1:0]  r_fail_code, w_next_fail_code;
    logic [31:0] r_bad_data, w_next_bad_data;
    logic [31:0] r_last_pc, w_next_last_pc;
    logic        r_pass, r_fail;
    logic        w_hit, w_match, w_timeout;

    assign w_hit     = bus.memwrite && (bus.aluout == EXP_ADDR);
    assign w_match   = (bus.writedata == EXP_DATA);
    assign w_timeout = (r_cycles == LP_LAST_CYCLE);

    always_comb begin
        w_next_state       = r_state;
        w_next_cycles      = r_cycles;
        w_next_store_count = r_store_count;
        w_next_fail_code   = r_fail_code;
        w_next_bad_data    = r_bad_data;
        w_next_last_pc     = r_last_pc;
        if (r_state == ST_RUN) begin
            w_next_cycles = r_cycles + 16'd1;
            if (bus.memwrite && (r_store_count != 16'hFFFF)) begin
                w_next_store_count = r_store_count + 16'd1;
            end
            // The result store wins over a timeout landing on the same edge.
            if (w_hit) begin
                w_next_last_pc = bus.pc;
                if (w_match) begin
                    w_next_state = ST_PASS;
                end else begin
                    w_next_state     = ST_FAIL;
                    w_next_fail_code = 2'b01;
                    w_next_bad_data  = bus.writedata;
                end
            end else if (w_timeout) begin
                w_next_state     = ST_FAIL;
                w_next_fail_code = 2'b10;
                w_next_last_pc   = bus.pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_cycles      <= 16'd0;
            r_store_count <= 16'd0;
            r_fail_code   <= 2'b00;
            r_bad_data    <= 32'd0;
            r_last_pc     <= 32'd0;
            r_pass        <= 1'b0;
            r_fail        <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_cycles      <= w_next_cycles;
            r_store_count <= w_next_store_count;
            r_fail_code   <= w_next_fail_code;
            r_bad_data    <= w_next_bad_data;
            r_last_pc     <= w_next_last_pc;
            r_pass        <= (w_next_state == ST_PASS);
            r_fail        <= (w_next_state == ST_FAIL);
        end
    end

    assign bus.done        = r_pass | r_fail;
    assign bus.pass        = r_pass;
    assign bus.fail        = r_fail;
    assign bus.fail_code   = r_fail_code;
    assign bus.store_count = r_store_count;
    assign bus.bad_data    = r_bad_data;
    assign bus.last_pc     = r_last_pc;
    assign bus.dbg_state   = r_state;

endmodule

// File: doc/store_monitor.md
STORE_MONITOR -- requirements
Module: store_monitor

Interface
REQ-001 Parameter EXP_ADDR, default 32'h00000054, data-memory address of the final result store.
REQ-002 Parameter EXP_DATA, default 32'h00000007, value that must be written to EXP_ADDR.
REQ-003 Parameter TIMEOUT, default 16'd1000, RUN cycles allowed before a verdict is forced.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 memwrite  input  1  processor data-memory write strobe, valid every cycle.
REQ-007 pc  input  32  processor program counter, used only for the last_pc capture.
REQ-008 aluout  input  32  data-memory address; qualified by memwrite.
REQ-009 writedata  input  32  data-memory write data; qualified by memwrite.
REQ-010 done  output  1  verdict reached; sticky.
REQ-011 pass  output  1  expected store observed with correct data.
REQ-012 fail  output  1  wrong data at EXP_ADDR, or timeout.
REQ-013 fail_code  output  2  00 none, 01 data mismatch, 10 timeout, 11 reserved (never driven).
REQ-014 store_count  output  16  number of qualified stores seen in RUN.
REQ-015 bad_data  output  32  writedata captured on a mismatch; otherwise 0.
REQ-016 last_pc  output  32  pc sampled on the verdict cycle.

Function
REQ-017 States: RUN, PASS, FAIL; encoding free; all outputs registered.
REQ-018 In RUN, each rising edge shall increment an internal 16-bit cycle counter by 1.
REQ-019 In RUN, memwrite=1 shall increment store_count by 1; store_count saturates at 16'hFFFF.
REQ-020 In RUN, memwrite=1 with aluout==EXP_ADDR and writedata==EXP_DATA -> next state PASS, pass=1, done=1.
REQ-021 In RUN, memwrite=1 with aluout==EXP_ADDR and writedata!=EXP_DATA -> next state FAIL, fail=1, done=1, fail_code=01, bad_data=writedata.
REQ-022 Stores to any other address only increment store_count; no state change.
REQ-023 In RUN, cycle counter==TIMEOUT-1 with no qualifying store on that edge -> next state FAIL, fail_code=10.
REQ-024 A qualifying store on the timeout edge takes priority over the timeout.
REQ-025 The verdict is visible on outputs the cycle after the edge that sampled the deciding inputs (1-cycle latency).
REQ-026 last_pc shall capture pc on the same edge that moves the state out of RUN.
REQ-027 PASS and FAIL are terminal: the counter, store_count and all outputs hold until reset, whatever memwrite/aluout do.
REQ-028 pass and fail are never both 1; done == pass|fail at all times.
REQ-029 Address and data compares are full 32-bit equality; no byte masking.

Reset
REQ-030 reset=1 at a rising edge -> state RUN, cycle counter 0, store_count 0, done/pass/fail 0, fail_code 00, bad_data 0, last_pc 0.
REQ-031 Reset dominates all other inputs on the same edge, including a qualifying store.
REQ-032 Reset asserted from PASS or FAIL shall clear the verdict and restart monitoring.
REQ-033 Outputs are undefined before the first reset edge; the bench shall apply reset for at least 1 cycle.

Verification
REQ-034 Reset, 3 stores to 0x50, then store 7 to 0x54 -> next cycle pass=1, done=1, fail=0, store_count=4.
REQ-035 Reset, store 9 to 0x54 -> next cycle fail=1, fail_code=01, bad_data=9, pass=0.
REQ-036 Reset, TIMEOUT=8, no stores -> fail=1 and fail_code=10 visible after edge 8; done=0 before it.
REQ-037 TIMEOUT=8, store 7 to 0x54 on edge 8 -> pass=1, fail_code=00 (store beats timeout).
REQ-038 After PASS, store 9 to 0x54 -> outputs unchanged; then reset=1 one cycle -> all outputs 0, state RUN.
REQ-039 Reset asserted in the same cycle as store 7 to 0x54 -> after the edge, done=0 and store_count=0.
